// File: rtl/mem_arb_pkg.sv
// Shared constants for the RAM data-port arbiter: port ids and lock counter sizing.
package mem_arb_pkg;

  localparam logic PORT_CORE   = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  // Wide enough to hold values 0..max_lock inclusive.
  function automatic int lock_cnt_width(input int max_lock);
    return (max_lock < 1) ? 1 : $clog2(max_lock + 1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector with an optional bounded lock.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  input  logic       i_lock_owner_valid,
  input  logic       i_lock_owner,
  input  logic       i_lock_expired,
  output logic       o_grant_valid,
  output logic       o_grant_id
);

  always_comb begin
    o_grant_valid = |i_valid;
    o_grant_id    = PORT_CORE;
    case (i_valid)
      2'b01:   o_grant_id = PORT_CORE;
      2'b10:   o_grant_id = PORT_LOADER;
      // Contention: honour an unexpired lock, otherwise alternate.
      2'b11:   o_grant_id = (i_lock_owner_valid && !i_lock_expired) ? i_lock_owner
                                                                     : ~i_last_grant;
      default: o_grant_id = PORT_CORE;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single RAM data port between the core (port 0) and the loader (port 1);
// one access per cycle, read data returned on a registered response one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_wEn,
  input  logic                  i_req0_lock,
  input  logic [ADDR_WIDTH-1:0] i_req0_address,
  input  logic [DATA_WIDTH-1:0] i_req0_write_data,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_wEn,
  input  logic                  i_req1_lock,
  input  logic [ADDR_WIDTH-1:0] i_req1_address,
  input  logic [DATA_WIDTH-1:0] i_req1_write_data,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_read_data,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_read_data,
  output logic                  o_wEn,
  output logic [ADDR_WIDTH-1:0] o_d_address,
  output logic [DATA_WIDTH-1:0] o_d_write_data,
  input  logic [DATA_WIDTH-1:0] i_d_read_data,
  output logic                  o_grant_owner
);

  localparam int              LockW   = lock_cnt_width(MAX_LOCK);
  localparam logic [LockW-1:0] LockMax = LockW'(MAX_LOCK);

  logic                  r_last_grant;
  logic                  r_grant_owner;
  logic                  r_lock_valid;
  logic                  r_lock_owner;
  logic [LockW-1:0]      r_lock_count;
  logic [1:0]            r_rsp_pending;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  logic                  w_grant_valid;
  logic                  w_grant_id;
  logic                  w_accept;
  logic                  w_lock_expired;
  logic                  w_sel_wEn;
  logic                  w_sel_lock;
  logic [ADDR_WIDTH-1:0] w_sel_address;
  logic [DATA_WIDTH-1:0] w_sel_write_data;

  assign w_lock_expired = (r_lock_count >= LockMax);

  rr_pick2 u_pick (
    .i_valid            ({i_req1_valid, i_req0_valid}),
    .i_last_grant       (r_last_grant),
    .i_lock_owner_valid (r_lock_valid),
    .i_lock_owner       (r_lock_owner),
    .i_lock_expired     (w_lock_expired),
    .o_grant_valid      (w_grant_valid),
    .o_grant_id         (w_grant_id)
  );

  // Reset masks every handshake so nothing reaches the RAM while it is held.
  assign w_accept = w_grant_valid && !i_reset;

  always_comb begin
    w_sel_wEn        = 1'b0;
    w_sel_lock       = 1'b0;
    w_sel_address    = '0;
    w_sel_write_data = '0;
    if (w_accept) begin
      if (w_grant_id == PORT_LOADER) begin
        w_sel_wEn        = i_req1_wEn;
        w_sel_lock       = i_req1_lock;
        w_sel_address    = i_req1_address;
        w_sel_write_data = i_req1_write_data;
      end else begin
        w_sel_wEn        = i_req0_wEn;
        w_sel_lock       = i_req0_lock;
        w_sel_address    = i_req0_address;
        w_sel_write_data = i_req0_write_data;
      end
    end
  end

  assign o_req0_ready   = w_accept && (w_grant_id == PORT_CORE);
  assign o_req1_ready   = w_accept && (w_grant_id == PORT_LOADER);
  assign o_wEn          = w_sel_wEn;
  assign o_d_address    = w_sel_address;
  assign o_d_write_data = w_sel_write_data;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_last_grant  <= PORT_LOADER;
      r_grant_owner <= PORT_CORE;
      r_lock_valid  <= 1'b0;
      r_lock_owner  <= PORT_CORE;
      r_lock_count  <= '0;
      r_rsp_pending <= 2'b00;
      r_rsp_data    <= '0;
    end else begin
      r_rsp_pending <= 2'b00;
      if (w_accept) begin
        r_last_grant  <= w_grant_id;
        r_grant_owner <= w_grant_id;
        if (!w_sel_wEn) begin
          r_rsp_pending <= {w_grant_id == PORT_LOADER, w_grant_id == PORT_CORE};
          r_rsp_data    <= i_d_read_data;
        end
        // A lock request continues the owner's run, or starts a new run of one.
        if (w_sel_lock) begin
          r_lock_valid <= 1'b1;
          r_lock_owner <= w_grant_id;
          if (r_lock_valid && (r_lock_owner == w_grant_id)) begin
            r_lock_count <= (r_lock_count >= LockMax) ? LockMax : r_lock_count + 1'b1;
          end else begin
            r_lock_count <= LockW'(1);
          end
        end else begin
          r_lock_valid <= 1'b0;
          r_lock_count <= '0;
        end
      end
    end
  end

  assign o_rsp0_valid     = r_rsp_pending[0];
  assign o_rsp1_valid     = r_rsp_pending[1];
  assign o_rsp0_read_data = r_rsp_data;
  assign o_rsp1_read_data = r_rsp_data;
  assign o_grant_owner    = r_grant_owner;

endmodule
